// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants.
// Operands are converted to magnitudes at accept, one quotient bit is produced per
// BUSY cycle, and a final BUSY cycle applies sign correction and result selection.
module div_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      op,
  input  logic            word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] c
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [XLEN-1:0]   quo_q, rem_q, dvs_q, c_q;
  logic              neg_quo_q, neg_rem_q, sel_rem_q, word_q;

  // Operand preparation signals
  logic              sgn, sa, sb, div_zero, ovf;
  logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b, min_val;
  // Iteration signals
  logic              qbit;
  logic [XLEN:0]     diff_low;
  logic [XLEN-1:0]   rem_sh, rem_nx, quo_nx;
  // Finalisation signals
  logic [XLEN-1:0]   q_fin, r_fin, res, res_fin;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign c         = c_q;

  // Accept-time operand extension, magnitude conversion and special-case detection
  always_comb begin
    sgn     = ~op[0];
    a_ext   = a;
    b_ext   = b;
    min_val = {1'b1, {(XLEN-1){1'b0}}};
    if (word) begin
      a_ext   = {{(XLEN-32){sgn & a[31]}}, a[31:0]};
      b_ext   = {{(XLEN-32){sgn & b[31]}}, b[31:0]};
      min_val = {{(XLEN-32){1'b1}}, 32'h8000_0000};
    end
    sa       = sgn & a_ext[XLEN-1];
    sb       = sgn & b_ext[XLEN-1];
    mag_a    = sa ? -a_ext : a_ext;
    mag_b    = sb ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    ovf      = sgn & (a_ext == min_val) & (b_ext == '1);
  end

  // One shift-subtract-restore step; the remainder MSB shifted out forces a subtract
  always_comb begin
    rem_sh   = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    diff_low = {1'b0, rem_sh} - {1'b0, dvs_q};
    qbit     = rem_q[XLEN-1] | ~diff_low[XLEN];
    rem_nx   = qbit ? diff_low[XLEN-1:0] : rem_sh;
    quo_nx   = {quo_q[XLEN-2:0], qbit};
  end

  // Sign correction, quotient/remainder select and W sign-extension
  always_comb begin
    q_fin   = neg_quo_q ? -quo_q : quo_q;
    r_fin   = neg_rem_q ? -rem_q : rem_q;
    res     = sel_rem_q ? r_fin : q_fin;
    res_fin = word_q ? {{(XLEN-32){res[31]}}, res[31:0]} : res;
  end

  // Control FSM and datapath registers; flush overrides every transition
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      c_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
      word_q    <= 1'b0;
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q   <= StBusy;
            dvs_q     <= mag_b;
            sel_rem_q <= op[1];
            word_q    <= word;
            if (div_zero || ovf) begin
              // Zero count makes the first BUSY cycle the finalisation cycle
              cnt_q     <= '0;
              quo_q     <= div_zero ? '1 : mag_a;
              rem_q     <= div_zero ? mag_a : '0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= div_zero & sa;
            end else begin
              cnt_q     <= word ? CntW'(XLEN / 2) : CntW'(XLEN);
              quo_q     <= word ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
              rem_q     <= '0;
              neg_quo_q <= sa ^ sb;
              neg_rem_q <= sa;
            end
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            c_q     <= res_fin;
            state_q <= StDone;
          end else begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus control sequences
// (hold in DONE, flush in BUSY/IDLE/DONE, asynchronous reset mid-operation).
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [1:0]  op = '0;
  logic        word = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] c;

  int checks = 0;
  int errors = 0;

  div_unit #(.XLEN(64)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .word      (word),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic        w;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs [NVec];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for in_ready, presents one operation, and returns #1 after the accept edge
  task automatic do_accept(input logic [63:0] av, input logic [63:0] bv,
                           input logic [1:0] opv, input logic wv);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles", guard);
    end
    a = av; b = bv; op = opv; word = wv; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Operands must be ignored after the accept cycle
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    op = 2'($urandom_range(0, 3));
    word = 1'($urandom_range(0, 1));
  endtask

  // Counts edges after accept until out_valid, bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic pop(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_pop_valid"}, {63'd0, out_valid}, 64'd0);
    chk({name, "_pop_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_op(input string name, input logic [63:0] av, input logic [63:0] bv,
                        input logic [1:0] opv, input logic wv,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    do_accept(av, bv, opv, wv);
    wait_done(lat);
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_c"}, c, exp);
    pop(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;

    vecs[0]  = '{"divu_100_7",   64'd100, 64'd7, 2'd1, 1'b0, 64'd14, 65};
    vecs[1]  = '{"remu_100_7",   64'd100, 64'd7, 2'd3, 1'b0, 64'd2, 65};
    vecs[2]  = '{"div_m7_2",     64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'd0, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[3]  = '{"rem_m7_2",     64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'd2, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[4]  = '{"div_7_m2",     64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 2'd0, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[5]  = '{"rem_7_m2",     64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 2'd2, 1'b0, 64'd1, 65};
    vecs[6]  = '{"divu_5_0",     64'd5, 64'd0, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[7]  = '{"rem_m5_0",     64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 2'd2, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFB, 1};
    vecs[8]  = '{"divw_123_0",   64'h123, 64'd0, 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[9]  = '{"div_ovf",      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0,
                 64'h8000_0000_0000_0000, 1};
    vecs[10] = '{"rem_ovf",      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 1'b0,
                 64'd0, 1};
    vecs[11] = '{"divw_ovf",     64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b1,
                 64'hFFFF_FFFF_8000_0000, 1};
    vecs[12] = '{"divuw_big",    64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 2'd1, 1'b1,
                 64'h0000_0000_7FFF_FFFF, 33};
    vecs[13] = '{"remw_m7_2",    64'h0000_0000_FFFF_FFF9, 64'd2, 2'd2, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[14] = '{"divu_max_10",  64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 2'd1, 1'b0,
                 64'h1999_9999_9999_9999, 65};
    vecs[15] = '{"remu_max_10",  64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 2'd3, 1'b0, 64'd5, 65};
    vecs[16] = '{"divuw_upper",  64'hABCD_0000_0000_0064, 64'h1234_0000_0000_0007, 2'd1, 1'b1,
                 64'd14, 33};

    // Reset state
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_c", c, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].w, vecs[i].exp,
             vecs[i].lat);
    end

    // Result held in DONE while out_ready is low
    do_accept(64'd100, 64'd7, 2'd1, 1'b0);
    wait_done(lat);
    chk("hold_lat", 64'(lat), 64'd65);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_c", c, 64'd14);
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    pop("hold");

    // Flush at iteration 20 of a BUSY operation
    do_accept(64'd1000, 64'd3, 2'd1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_busy_valid", {63'd0, out_valid}, 64'd0);
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_busy_no_result", {63'd0, seen}, 64'd0);
    run_op("after_flush", 64'd9, 64'd3, 2'd1, 1'b0, 64'd3, 65);

    // Flush together with in_valid in IDLE: not accepted
    @(negedge clk);
    a = 64'd5; b = 64'd0; op = 2'd1; word = 1'b0;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_idle_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_idle_valid", {63'd0, out_valid}, 64'd0);

    // Flush in DONE discards the result even with out_ready high
    do_accept(64'd5, 64'd0, 2'd1, 1'b0);
    wait_done(lat);
    chk("flush_done_lat", 64'(lat), 64'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    out_ready = 1'b0;
    chk("flush_done_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_done_ready", {63'd0, in_ready}, 64'd1);

    // Asynchronous reset mid-BUSY takes effect before any clock edge
    do_accept(64'd12345, 64'd7, 2'd1, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("areset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("areset_valid", {63'd0, out_valid}, 64'd0);
    chk("areset_c", c, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("after_reset", 64'd9, 64'd3, 2'd1, 1'b0, 64'd3, 65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the execute stage. It implements RV64M DIV, DIVU, REM and REMU, plus the W variants.
- It complements the single-cycle ALU: execute hands an operand pair in through a valid/ready handshake, stalls while the unit is busy, and collects the 64-bit result through a second handshake.
- A flush input aborts an in-flight operation when the pipeline is redirected.

Parameters:
XLEN, 64, datapath width; only 64 is supported.

Ports:
clk  in  1  clock; all state changes on rising edge
resetn  in  1  asynchronous active-low reset
in_valid  in  1  operand pair and op are valid
in_ready  out  1  unit can accept an operation
a  in  XLEN  dividend (rs1)
b  in  XLEN  divisor (rs2)
op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
word  in  1  1 = W variant (32-bit operation)
flush  in  1  abort current operation, discard result
out_valid  out  1  c holds a final result
out_ready  in  1  consumer takes result
c  out  XLEN  quotient or remainder

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, in_ready=1, out_valid=0, c=0, all internal registers 0. Reset mid-operation drops the operation silently.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0. An iteration counter runs.
  - DONE: in_ready=0, out_valid=1, c stable.
- Accept: in_valid && in_ready at edge E0 latches a, b, op, word.
- Operand preparation at accept:
  - Word ops: operands are the low 32 bits; signed ops sign-extend from bit 31, unsigned ops zero-extend.
  - Signed ops: operands are converted to magnitudes, and the quotient and remainder signs are recorded. The quotient sign is sa^sb; the remainder sign is sa.
- Special cases, decided at accept. The unit goes directly to DONE, and out_valid is high after edge E0+1.
  - Divisor zero: quotient = all ones (0xFFFFFFFFFFFFFFFF); remainder = dividend as prepared.
  - Signed overflow: most-negative dividend / -1, meaning 0x8000000000000000, or 0x80000000 for W. Quotient = dividend; remainder = 0.
- Normal case:
  - BUSY runs N iterations, N=64 (N=32 for word). Each iteration is one shift-subtract-restore step producing one quotient bit.
  - On the last iteration, the result is sign-corrected, selected (quotient for op 0/1, remainder for op 2/3) and registered into c.
  - State becomes DONE; out_valid is high after edge E0+N+1.
- W result: the 32-bit result is sign-extended from bit 31 into c[63:32], for all four W ops, including the special cases.
- DONE:
  - c and out_valid hold indefinitely while out_ready=0.
  - out_valid && out_ready at an edge → IDLE. The next accept is possible no earlier than the following edge (no same-cycle turnaround).
- flush:
  - Sampled every edge; it has priority over every other transition. At the next edge the unit enters IDLE and out_valid=0.
  - c may hold a stale value; consumers ignore c when out_valid=0.
  - flush with in_valid in IDLE: the operation is not accepted.
  - flush in DONE: the result is discarded even if out_ready=1 in the same cycle.
- Inputs a, b, op and word are ignored except in the accept cycle. Changes during BUSY have no effect.
- in_ready is a pure function of state; there is no combinational path from in_valid to in_ready.

Test Plan:
- Unsigned division:
  - DIVU a=100, b=7 → c=14; out_valid rises exactly 65 edges after accept.
  - REMU with the same operands → c=2.
- Signed division:
  - DIV a=-7 (0xFFFFFFFFFFFFFFF9), b=2 → c=0xFFFFFFFFFFFFFFFD (-3).
  - REM → c=0xFFFFFFFFFFFFFFFF (-1).
  - DIV a=7, b=-2 → c=-3.
- Divide by zero:
  - DIVU a=5, b=0 → c=0xFFFFFFFFFFFFFFFF, valid after 1 edge.
  - REM a=-5, b=0 → c=-5.
  - DIVW a=0x123, b=0 → c=0xFFFFFFFFFFFFFFFF.
- Overflow:
  - DIV 0x8000000000000000 / -1 → c=0x8000000000000000; REM → c=0.
  - DIVW a=0x0000000080000000, b=0xFFFFFFFFFFFFFFFF → c=0xFFFFFFFF80000000.
- Word ops:
  - DIVUW a=0xFFFFFFFF_FFFFFFFE, b=2 → c=0x000000007FFFFFFF, sign-extended, so c=0x000000007FFFFFFF; valid 33 edges after accept.
  - REMW a=0x00000000_FFFFFFF9, b=2 → c=0xFFFFFFFFFFFFFFFF.
- Control:
  - Hold out_ready=0 for 10 cycles in DONE → c stable, in_ready=0.
  - Assert flush at iteration 20 → IDLE next edge, no out_valid.
  - Drop resetn mid-BUSY → outputs reset immediately, without waiting for a clock edge.
  - A new DIVU 9/3 after either flush or reset → c=3.
